// File: rtl/ucsbece154b_evict_buffer.sv
// Victim-side FIFO between L1 evictions and the victim cache, coalescing duplicate tags, with same-cycle lookup.
// Zero-latency combinational drain/lookup; evict_ready_o drops when full with no coalesce match or on flush.
module ucsbece154b_evict_buffer #(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         evict_valid_i,
  output logic                         evict_ready_o,
  input  logic [ADDR_WIDTH-1:0]        evict_addr_i,
  input  logic [LINE_WIDTH-1:0]        evict_data_i,
  input  logic                         drain_en_i,
  output logic                         vc_we_o,
  output logic [ADDR_WIDTH-1:0]        vc_waddr_o,
  output logic [LINE_WIDTH-1:0]        vc_wdata_o,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic [LINE_WIDTH-1:0]        lookup_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH/8);
  localparam int TAG_SIZE     = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int PTR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W        = $clog2(DEPTH+1);

  logic [DEPTH-1:0]      valid_q;
  logic [TAG_SIZE-1:0]   tag_q  [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;

  logic [TAG_SIZE-1:0]   evict_tag, lookup_tag;
  logic [DEPTH-1:0]      coal_match, lookup_match;
  logic                  empty, full, pop, coal_hit, accept, push;
  logic                  unused_offsets;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign evict_tag      = evict_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign lookup_tag     = lookup_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign unused_offsets = ^{evict_addr_i[OFFSET_WIDTH-1:0], lookup_addr_i[OFFSET_WIDTH-1:0]};

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = drain_en_i && !empty && !flush_i;

  // The head leaving this cycle cannot absorb a coalesce; the new line is queued instead.
  always_comb begin
    coal_match   = '0;
    lookup_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      coal_match[i]   = valid_q[i] && (tag_q[i] == evict_tag) && !(pop && (head_q == PTR_W'(i)));
      lookup_match[i] = valid_q[i] && (tag_q[i] == lookup_tag) && !flush_i;
    end
  end

  assign coal_hit      = |coal_match;
  assign evict_ready_o = !flush_i && (!full || coal_hit);
  assign accept        = evict_valid_i && evict_ready_o;
  assign push          = accept && !coal_hit;

  assign vc_we_o    = pop;
  assign vc_waddr_o = empty ? '0 : {tag_q[head_q], {OFFSET_WIDTH{1'b0}}};
  assign vc_wdata_o = empty ? '0 : data_q[head_q];
  assign count_o    = count_q;

  always_comb begin
    lookup_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (lookup_match[i]) lookup_data_o = lookup_data_o | data_q[i];
    end
  end
  assign lookup_hit_o = |lookup_match;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ptr_inc(tail_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset: valid_q gates every consumer.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_q[tail_q]  <= evict_tag;
      data_q[tail_q] <= evict_data_i;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && coal_match[i]) data_q[i] <= evict_data_i;
    end
  end
endmodule
